// File: rtl/board_rst_seq.sv
// -----------------------------------------------------------------------------
// board_rst_seq
//   Board-level reset sequencer. It sits between the clock PLL and the SoC.
//   It synchronises the board reset button and qualifies PLL lock over a
//   stability window. It then releases NUM_DOMAINS active-high domain resets in
//   index order, spaced STAGE_GAP_CYCLES apart. A soft reset can be requested
//   from software or debug. The cause of the last reset is recorded.
//
//   Optional feature macro: RST_SEQ_WDT_EN
//     When defined, the wdt_kick_i port and a RUN-state watchdog are added.
//     The watchdog requires WDT_CYCLES >= 2.
//
//   Ports
//     clk_i           PLL output clock
//     arst_n_i        board reset, async assert, synchronised release
//     pll_locked_i    PLL lock, asynchronous to clk_i
//     soft_rst_req_i  soft-reset request (level or pulse), edge-armed
//     wdt_kick_i      watchdog kick (RST_SEQ_WDT_EN only)
//     rst_o           active-high domain resets, rst_o[0] released first
//     ready_o         all domains released
//     state_o         0 HOLD, 1 RELEASE, 2 RUN, 3 SOFT
//     rst_cause_o     0 board, 1 PLL lock loss, 2 soft, 3 watchdog
// -----------------------------------------------------------------------------
module board_rst_seq #(
  parameter int NUM_DOMAINS        = 2,
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP_CYCLES   = 16,
  parameter int SOFT_RST_CYCLES    = 64,
  parameter int WDT_CYCLES         = 16777216
) (
  input  logic                   clk_i,
  input  logic                   arst_n_i,
  input  logic                   pll_locked_i,
  input  logic                   soft_rst_req_i,
`ifdef RST_SEQ_WDT_EN
  input  logic                   wdt_kick_i,
`endif
  output logic [NUM_DOMAINS-1:0] rst_o,
  output logic                   ready_o,
  output logic [1:0]             state_o,
  output logic [1:0]             rst_cause_o
);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_SOFT    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_BOARD = 2'd0,
    CAUSE_PLL   = 2'd1,
    CAUSE_SOFT  = 2'd2,
    CAUSE_WDT   = 2'd3
  } cause_t;

  // The lock window, stage gap, soft hold and watchdog never run at the same
  // time, so a single counter serves all of them. It is sized for the
  // largest terminal value.
  localparam int CNT_MAX_BASE =
    (LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES)
      ? ((LOCK_STABLE_CYCLES > SOFT_RST_CYCLES) ? LOCK_STABLE_CYCLES : SOFT_RST_CYCLES)
      : ((STAGE_GAP_CYCLES > SOFT_RST_CYCLES) ? STAGE_GAP_CYCLES : SOFT_RST_CYCLES);
`ifdef RST_SEQ_WDT_EN
  localparam int CNT_MAX = (WDT_CYCLES > CNT_MAX_BASE) ? WDT_CYCLES : CNT_MAX_BASE;
`else
  localparam int CNT_MAX = CNT_MAX_BASE;
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] LOCK_TERM = CNT_W'(LOCK_STABLE_CYCLES);
  localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(STAGE_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SOFT_TERM = CNT_W'(SOFT_RST_CYCLES - 1);
  // The timeout fires on the edge where the count would reach WDT_CYCLES-1.
  localparam logic [CNT_W-1:0] WDT_TERM  = CNT_W'(WDT_CYCLES - 2);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

  // ---------------------------------------------------------------------------
  // Synchronisers
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] rst_sync;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   rst_int_n;
  logic                   locked_s;

  // NOTE: sequential state is always written with non-blocking (<=)
  // assignments. Flops that sample each other then see pre-edge values
  // regardless of the order in which the blocks are evaluated.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) rst_sync <= '0;
    else           rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
  end

  assign rst_int_n = rst_sync[SYNC_STAGES-1];

  // The lock synchroniser is held in reset until the internal reset releases.
  // As a result, locked_s only becomes valid after the internal reset is gone.
  always_ff @(posedge clk_i or negedge rst_int_n) begin
    if (!rst_int_n) lock_sync <= '0;
    else            lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked_i};
  end

  assign locked_s = lock_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Watchdog hookup. Without the feature, the kick is tied active. This keeps
  // the RUN counter cleared, so the timeout can never fire.
  // ---------------------------------------------------------------------------
  logic wdt_kick;
`ifdef RST_SEQ_WDT_EN
  assign wdt_kick = wdt_kick_i;
`else
  assign wdt_kick = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  state_t                 state_q, state_d;
  cause_t                 cause_q, cause_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   armed_q, armed_d;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic                   ready_q, ready_d;

  always_comb begin
    // NOTE: every signal is given a default before the case statement. Any
    // path that leaves one unassigned would otherwise infer a latch.
    state_d = state_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    armed_d = armed_q;

    unique case (state_q)
      ST_HOLD: begin
        if (!locked_s) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_TERM) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RELEASE: begin
        if (!locked_s) begin
          state_d = ST_HOLD;
          cause_d = CAUSE_PLL;
          cnt_d   = '0;
        end else if (idx_q == IDX_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q == GAP_TERM) begin
          idx_d = idx_q + IDX_W'(1);
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_HOLD;
          cause_d = CAUSE_PLL;
          cnt_d   = '0;
        end else if (!wdt_kick && cnt_q == WDT_TERM) begin
          state_d = ST_SOFT;
          cause_d = CAUSE_WDT;
          cnt_d   = '0;
        end else if (soft_rst_req_i && armed_q) begin
          state_d = ST_SOFT;
          cause_d = CAUSE_SOFT;
          cnt_d   = '0;
          armed_d = 1'b0;
        end else begin
          // A request still held from the previous soft reset must drop
          // before it can fire again.
          if (!soft_rst_req_i) armed_d = 1'b1;
          cnt_d = wdt_kick ? '0 : cnt_q + CNT_W'(1);
        end
      end

      ST_SOFT: begin
        if (!locked_s) begin
          state_d = ST_HOLD;
          cause_d = CAUSE_PLL;
          cnt_d   = '0;
        end else if (cnt_q == SOFT_TERM) begin
          // Lock is still good, so release without re-qualification.
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = ST_HOLD;
    endcase

    // The outputs are decoded from the next state and then registered. This
    // keeps them glitch-free, and assertion lands on the same edge as the
    // state change.
    rst_d   = '1;
    ready_d = 1'b0;
    if (state_d == ST_RELEASE) begin
      for (int k = 0; k < NUM_DOMAINS; k++) rst_d[k] = (k > int'(idx_d));
    end else if (state_d == ST_RUN) begin
      rst_d   = '0;
      ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= ST_HOLD;
      cause_q <= CAUSE_BOARD;
      cnt_q   <= '0;
      idx_q   <= '0;
      armed_q <= 1'b1;
      rst_q   <= '1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      armed_q <= armed_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
    end
  end

  assign rst_o       = rst_q;
  assign ready_o     = ready_q;
  assign state_o     = state_q;
  assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_board_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_board_rst_seq
//   Directed bench for board_rst_seq with NUM_DOMAINS=3, SYNC_STAGES=2,
//   LOCK_STABLE_CYCLES=8, STAGE_GAP_CYCLES=4, SOFT_RST_CYCLES=5 and
//   WDT_CYCLES=32. The stimulus pushes expected output changes, each with
//   its edge number, into a queue. A monitor compares every observed change
//   of {rst_o, ready_o, state_o, rst_cause_o} against the head of that queue.
//   Edge n is the rising edge on which cyc becomes n.
//   Define RST_SEQ_WDT_EN to include the watchdog scenario.
// -----------------------------------------------------------------------------
module tb_board_rst_seq;

  typedef struct {
    string      name;
    int         edge_n;   // -1: asynchronous event, edge not checked
    logic [7:0] tuple;    // {rst_o, ready_o, state_o, rst_cause_o}
  } ev_t;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       pll_locked;
  logic       soft_req;
`ifdef RST_SEQ_WDT_EN
  logic       kick;
`endif
  logic [2:0] rst_o;
  logic       ready_o;
  logic [1:0] state_o;
  logic [1:0] rst_cause_o;

  int  cyc     = 0;
  int  n_pass  = 0;
  int  n_check = 0;
  ev_t exp_q[$];

  board_rst_seq #(
    .NUM_DOMAINS       (3),
    .SYNC_STAGES       (2),
    .LOCK_STABLE_CYCLES(8),
    .STAGE_GAP_CYCLES  (4),
    .SOFT_RST_CYCLES   (5),
    .WDT_CYCLES        (32)
  ) dut (
    .clk_i         (clk),
    .arst_n_i      (arst_n),
    .pll_locked_i  (pll_locked),
    .soft_rst_req_i(soft_req),
`ifdef RST_SEQ_WDT_EN
    .wdt_kick_i    (kick),
`endif
    .rst_o         (rst_o),
    .ready_o       (ready_o),
    .state_o       (state_o),
    .rst_cause_o   (rst_cause_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_check++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cyc %0d)", name, got, exp, cyc);
  endtask

  task automatic wait_edge(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_ev(input string nm, input int e, input logic [2:0] r,
                        input logic rd, input logic [1:0] st, input logic [1:0] c);
    ev_t ev;
    ev.name   = nm;
    ev.edge_n = e;
    ev.tuple  = {r, rd, st, c};
    exp_q.push_back(ev);
  endtask

  // Staggered release starting at edge t0 (4-cycle gap), then RUN one edge
  // after the last domain is released.
  task automatic exp_seq(input string nm, input int t0, input logic [1:0] c);
    exp_ev({nm, "_rel0"}, t0,     3'b110, 1'b0, 2'd1, c);
    exp_ev({nm, "_rel1"}, t0 + 4, 3'b100, 1'b0, 2'd1, c);
    exp_ev({nm, "_rel2"}, t0 + 8, 3'b000, 1'b0, 2'd1, c);
    exp_ev({nm, "_run"},  t0 + 9, 3'b000, 1'b1, 2'd2, c);
  endtask

  // Monitor: every change of the observable outputs is one event.
  logic [7:0] last_tuple = 'x;
  logic [7:0] cur_tuple;
  ev_t        mon_ev;
  int         got_edge;

  always @(negedge clk) begin
    cur_tuple = {rst_o, ready_o, state_o, rst_cause_o};
    if (cur_tuple !== last_tuple) begin
      last_tuple = cur_tuple;
      if (exp_q.size() == 0) begin
        n_check++;
        $display("FAIL unexpected_change: got %b expected no change (cyc %0d)", cur_tuple, cyc);
      end else begin
        mon_ev   = exp_q.pop_front();
        got_edge = (mon_ev.edge_n < 0) ? -1 : cyc;
        check(mon_ev.name, {got_edge, cur_tuple}, {mon_ev.edge_n, mon_ev.tuple});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int e0, r, a, b, s, h, f, r2;

    arst_n     = 1'b0;
    pll_locked = 1'b1;
    soft_req   = 1'b0;
`ifdef RST_SEQ_WDT_EN
    kick       = 1'b1;  // held active so RUN dwell in tests 1-5 never times out
`endif

    // 1. Power-up with lock constant high.
    exp_ev("por", -1, 3'b111, 1'b0, 2'd0, 2'd0);
    wait_edge(3);
    arst_n = 1'b1;
    e0 = 4;
    exp_seq("pwrup", e0 + 12, 2'd0);
    wait_edge(e0 + 24);

    // 2. Board reset, then a one-cycle locked_s glitch after 5 qualified
    //    cycles.
    exp_ev("rst_t2", -1, 3'b111, 1'b0, 2'd0, 2'd0);
    arst_n = 1'b0;
    #1;
    check("async_rst_t2", {rst_o, ready_o, state_o, rst_cause_o}, {3'b111, 1'b0, 2'd0, 2'd0});
    wait_edge(e0 + 26);
    arst_n = 1'b1;
    e0 = e0 + 27;
    exp_seq("glitch", e0 + 18, 2'd0);
    wait_edge(e0 + 6);
    pll_locked = 1'b0;
    wait_edge(e0 + 7);
    pll_locked = 1'b1;
    r = e0 + 27;
    wait_edge(r + 3);

    // 3. Lock loss in RUN, then re-lock.
    a = r + 4;
    exp_ev("lockloss", a + 2, 3'b111, 1'b0, 2'd0, 2'd1);
    pll_locked = 1'b0;
    wait_edge(r + 12);
    pll_locked = 1'b1;
    b = r + 13;
    exp_seq("relock", b + 10, 2'd1);
    r = b + 19;
    wait_edge(r + 2);

    // 4a. One-cycle soft request.
    s = r + 3;
    exp_ev("soft_pulse", s, 3'b111, 1'b0, 2'd3, 2'd2);
    exp_seq("soft_pulse", s + 5, 2'd2);
    soft_req = 1'b1;
    wait_edge(s);
    soft_req = 1'b0;
    r = s + 14;
    wait_edge(r + 2);

    // 4b. A held request causes exactly one soft reset.
    h = r + 3;
    exp_ev("soft_held", h, 3'b111, 1'b0, 2'd3, 2'd2);
    exp_seq("soft_held", h + 5, 2'd2);
    soft_req = 1'b1;
    wait_edge(h + 30);
    soft_req = 1'b0;

    // 5a. Lock loss and soft request on the same edge: lock loss wins.
    a = h + 33;
    exp_ev("simul", a + 2, 3'b111, 1'b0, 2'd0, 2'd1);
    wait_edge(a - 1);
    pll_locked = 1'b0;
    wait_edge(a + 1);
    soft_req = 1'b1;
    wait_edge(a + 2);
    soft_req = 1'b0;
    wait_edge(a + 9);
    pll_locked = 1'b1;
    b = a + 10;
    exp_ev("simul_rel0", b + 10, 3'b110, 1'b0, 2'd1, 2'd1);
    wait_edge(b + 12);

    // 5b. Board reset pulse during RELEASE.
    exp_ev("rst_mid", -1, 3'b111, 1'b0, 2'd0, 2'd0);
    arst_n = 1'b0;
    #1;
    check("async_rst_mid", {rst_o, ready_o, state_o, rst_cause_o}, {3'b111, 1'b0, 2'd0, 2'd0});
    wait_edge(b + 14);
    arst_n = 1'b1;
    e0 = b + 15;
    exp_seq("rerun", e0 + 12, 2'd0);
    f = e0 + 21;
`ifdef RST_SEQ_WDT_EN
    // 6. Watchdog: no kicks from RUN entry, then a kick on the terminal cycle
    //    and every 20 cycles after that.
    wait_edge(e0 + 15);
    kick = 1'b0;
    exp_ev("wdt_to", f + 31, 3'b111, 1'b0, 2'd3, 2'd3);
    exp_seq("wdt", f + 36, 2'd3);
    r2 = f + 45;
    wait_edge(r2 + 30);
    kick = 1'b1;
    wait_edge(r2 + 31);
    kick = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      wait_edge(r2 + 31 + 20 * i - 1);
      kick = 1'b1;
      wait_edge(r2 + 31 + 20 * i);
      kick = 1'b0;
    end
    wait_edge(r2 + 31 + 1000 + 5);
    kick = 1'b1;
`else
    r2 = f;
`endif
    wait_edge(r2 + 10);

    // Every expected event must have been observed.
    while (exp_q.size() > 0) begin
      mon_ev = exp_q.pop_front();
      n_check++;
      $display("FAIL %s: got no event expected %b at edge %0d", mon_ev.name, mon_ev.tuple, mon_ev.edge_n);
    end

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule

// File: doc/board_rst_seq.md
Name: board_rst_seq

Overview:
Parametrised board-level reset sequencer, instantiated in each board top between the clock PLL and the SoC instance. It replaces ad-hoc reset gating of the form "button AND pll_locked". The block synchronises the board reset, qualifies PLL lock with a stability window, and releases NUM_DOMAINS reset outputs in a staggered order. It adds a software/debug-issued soft reset and records the cause of the last reset.

Parameters:
NUM_DOMAINS, 2, number of reset outputs, released in index order (1..8).
SYNC_STAGES, 2, flop count of the arst_n_i release synchroniser and of the pll_locked_i synchroniser (>=2).
LOCK_STABLE_CYCLES, 1024, consecutive synchronised-lock cycles required before release (>=1).
STAGE_GAP_CYCLES, 16, cycles between successive domain releases (>=1).
SOFT_RST_CYCLES, 64, soft-reset hold length in cycles (>=1).
WDT_CYCLES, 16777216, watchdog timeout; used only with RST_SEQ_WDT_EN.

Ports:
clk_i  input  1  PLL output clock.
arst_n_i  input  1  asynchronous active-low reset (board button); assert async, release through SYNC_STAGES synchroniser.
pll_locked_i  input  1  PLL lock, asynchronous to clk_i.
soft_rst_req_i  input  1  synchronous soft-reset request, level or pulse.
wdt_kick_i  input  1  watchdog kick; port exists only with RST_SEQ_WDT_EN.
rst_o  output  NUM_DOMAINS  active-high domain resets.
ready_o  output  1  all domains released.
state_o  output  2  FSM state: 0 HOLD, 1 RELEASE, 2 RUN, 3 SOFT.
rst_cause_o  output  2  last reset cause: 0 board, 1 PLL lock loss, 2 soft, 3 watchdog.

Behaviour:
- arst_n_i low: all flops cleared asynchronously, including both synchronisers.
  - Output values: rst_o all ones, ready_o 0, state_o 0, rst_cause_o 0.
  - rst_cause_o is cleared only by arst_n_i; soft, PLL-loss and watchdog events overwrite it.
- Edge numbering: edge 0 is the first rising clk_i edge after arst_n_i rises. The internal reset releases after SYNC_STAGES edges. locked_s (pll_locked_i through SYNC_STAGES flops) becomes valid after that.
- HOLD:
  - rst_o all 1; lock counter increments on each locked_s=1 cycle and clears on locked_s=0.
  - After LOCK_STABLE_CYCLES consecutive locked_s=1 cycles, go to RELEASE.
  - Example: with pll_locked_i constantly high, rst_o[0] falls at edge 2*SYNC_STAGES+LOCK_STABLE_CYCLES.
- RELEASE:
  - rst_o[0] falls on the RELEASE entry edge; rst_o[k] falls STAGE_GAP_CYCLES edges after rst_o[k-1].
  - The edge after rst_o[NUM_DOMAINS-1] falls: go to RUN, ready_o=1.
  - NUM_DOMAINS=1: go to RUN one edge after entry.
- RUN: ready_o=1, rst_o all 0.
- Reset assertion (any state except the arst path): all rst_o go to 1 and ready_o to 0 on the same registered edge as the state change; there is no staggering on assertion.
- Event priority, highest first: locked_s=0, then watchdog, then soft_rst_req_i.
  - locked_s=0 in RELEASE/RUN/SOFT: go to HOLD, cause=1, lock counter cleared.
  - soft_rst_req_i=1 in RUN: go to SOFT, cause=2.
  - soft_rst_req_i in HOLD/RELEASE/SOFT is ignored and does not extend SOFT.
- SOFT:
  - rst_o all 1 for exactly SOFT_RST_CYCLES cycles.
  - Then go to RELEASE if locked_s=1 (no re-qualification), else to HOLD.
  - soft_rst_req_i still high on SOFT exit does not retrigger until it has been seen low in RUN (edge-armed).
- Counters are sized with $clog2 of the largest count; no wrap is possible, since each counter saturates or exits at its terminal value.
- arst_n_i asserted mid-sequence: immediate async return to the reset values above.

Optional Feature:
RST_SEQ_WDT_EN:
- Defined:
  - Adds the wdt_kick_i port and a watchdog counter active only in RUN.
  - The counter clears on wdt_kick_i=1 and on RUN entry.
  - When it reaches WDT_CYCLES-1: go to SOFT with cause=3, with the same SOFT timing as a soft reset.
  - A kick on the terminal cycle prevents the timeout.
- Undefined: no port, no counter, cause 3 is never produced.

Test Plan:
All tests use NUM_DOMAINS=3, SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, STAGE_GAP_CYCLES=4, SOFT_RST_CYCLES=5.
1. Power-up, pll_locked_i constant 1, arst_n_i released before edge 0 -> rst_o[0] falls at edge 12, rst_o[1] at 16, rst_o[2] at 20; ready_o=1 and state_o=2 at edge 21; rst_cause_o=0.
2. Lock glitch: locked_s low for 1 cycle after 5 qualified cycles in HOLD -> counter restarts; rst_o[0] falls 8 cycles after locked_s returns high.
3. In RUN, pll_locked_i falls -> rst_o=3'b111, ready_o=0, state_o=0, rst_cause_o=1 two to three edges later; re-lock -> full sequence repeats.
4. In RUN, 1-cycle soft_rst_req_i -> SOFT for 5 cycles, then RELEASE with 4-cycle stagger, RUN; rst_cause_o=2. A held-high request causes only one soft reset.
5. Simultaneous soft_rst_req_i and lock loss in RUN -> HOLD, cause=1. arst_n_i pulsed low during RELEASE -> rst_o=3'b111 asynchronously, cause=0.
6. RST_SEQ_WDT_EN, WDT_CYCLES=32: no kick -> SOFT at RUN-entry+31, cause=3; a kick every 20 cycles -> stays in RUN for 1000 cycles.
